ysyx_22040125_id_exe_hazard: RTL and testbench

- ID/EX pipeline register for the register-index/control slice, plus hazard control for the 5-stage RV64 core.
- Registers decoded operand indices into EXE; these feed the forwarding unit as exe_reg_rs1/exe_reg_rs2.
- Detects hazards that forwarding cannot cover: load-use, and JALR rs1 resolved in ID.
- Generates PC and IF/ID stalls, and inserts bubbles through a stall counter.

---
 rtl/ysyx_22040125_pipe_pkg.sv | 39 +++
 rtl/ysyx_22040125_hazard_detect.sv | 73 +++++++
 rtl/ysyx_22040125_id_exe_hazard.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22040125_id_exe_hazard.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040125_pipe_pkg
// Purpose  : Shared pipeline types and constants for the ID/EX hazard slice:
//            register index width, hazard-need encodings, and the ID/EX
//            control bubble.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040125_pipe_pkg;

  // Architectural register index width (x0..x31)
  localparam int REG_AW   = 5;
  // Widest stall any hazard can request is two cycles
  localparam int STALL_CW = 2;

  // Hazard-need encodings: number of bubble cycles a hazard requires
  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

  // Control slice carried through ID/EX
  typedef struct packed {
    logic valid;
    logic reg_wen;
    logic mem_ren;
  } idex_ctrl_t;

  // A bubble never writes a register and never reads memory
  localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '{valid: 1'b0, reg_wen: 1'b0, mem_ren: 1'b0};

  // 32-bit saturating accumulate for event counters
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040125_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040125_hazard_detect
// Purpose  : Combinational hazard-need computation for hazards forwarding
//            cannot cover: load-use, and JALR whose base register is read in
//            ID while its producer is still in EXE or is a load in MEM.
//            The need is split by class so the top can attribute stalls.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040125_hazard_detect
  import ysyx_22040125_pipe_pkg::*;
#(
  parameter int REG_AW   = ysyx_22040125_pipe_pkg::REG_AW,
  parameter int STALL_CW = ysyx_22040125_pipe_pkg::STALL_CW
) (
  input  logic                i_stall_idle,
  input  logic                i_id_valid,
  input  logic [REG_AW-1:0]   i_id_rs1,
  input  logic [REG_AW-1:0]   i_id_rs2,
  input  logic                i_id_rs1_used,
  input  logic                i_id_rs2_used,
  input  logic                i_id_is_jalr,
  input  logic                i_exe_valid,
  input  logic [REG_AW-1:0]   i_exe_rd,
  input  logic                i_exe_reg_wen,
  input  logic                i_exe_mem_ren,
  input  logic [REG_AW-1:0]   i_mem_rd,
  input  logic                i_mem_reg_wen,
  input  logic                i_mem_mem_ren,
  output logic [STALL_CW-1:0] o_need_lu,
  output logic [STALL_CW-1:0] o_need_jalr
);

  logic w_eval;
  logic w_exe_rd_nz;
  logic w_mem_rd_nz;
  logic w_lu;
  logic w_jx;
  logic w_jm;

  // Only a fresh ID instruction is checked; while the counter drains the
  // held instruction must not re-trigger a new stall.
  assign w_eval      = i_stall_idle & i_id_valid;
  assign w_exe_rd_nz = (i_exe_rd != '0);
  assign w_mem_rd_nz = (i_mem_rd != '0);

  assign w_lu = w_eval & i_exe_valid & i_exe_mem_ren & w_exe_rd_nz &
                ((i_id_rs1_used & (i_id_rs1 == i_exe_rd)) |
                 (i_id_rs2_used & (i_id_rs2 == i_exe_rd)));

  assign w_jx = w_eval & i_id_is_jalr & i_exe_valid & i_exe_reg_wen &
                w_exe_rd_nz & (i_id_rs1 == i_exe_rd);

  assign w_jm = w_eval & i_id_is_jalr & i_mem_reg_wen & i_mem_mem_ren &
                w_mem_rd_nz & (i_id_rs1 == i_mem_rd);

  // Per-class need; a JALR behind a load in EXE waits for the load to
  // leave MEM, hence two cycles.
  always_comb begin
    o_need_lu   = STALL_CW'(NEED_NONE);
    o_need_jalr = STALL_CW'(NEED_NONE);
    if (w_lu) begin
      o_need_lu = STALL_CW'(NEED_ONE);
    end
    if (w_jx && i_exe_mem_ren) begin
      o_need_jalr = STALL_CW'(NEED_TWO);
    end else if (w_jx || w_jm) begin
      o_need_jalr = STALL_CW'(NEED_ONE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040125_id_exe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040125_id_exe_hazard
// Purpose  : ID/EX register for the register-index/control slice plus stall
//            control. Priority each cycle: mem_busy freeze, EXE flush,
//            hazard stall (bubble + counter), normal advance.
//            Optional macro YSYX_22040125_HAZARD_PERF_EN adds saturating
//            stall-cycle counters o_perf_lu_cnt / o_perf_jalr_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040125_id_exe_hazard
#(
  parameter int REG_AW   = ysyx_22040125_pipe_pkg::REG_AW,
  parameter int STALL_CW = ysyx_22040125_pipe_pkg::STALL_CW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_wen,
  input  logic              i_id_mem_ren,
  input  logic              i_id_is_jalr,
  input  logic [REG_AW-1:0] i_mem_reg_rd,
  input  logic              i_mem_reg_reg_wen,
  input  logic              i_mem_reg_mem_ren,
  input  logic              i_mem_busy,
  input  logic              i_exe_flush,
  output logic [REG_AW-1:0] o_exe_reg_rs1,
  output logic [REG_AW-1:0] o_exe_reg_rs2,
  output logic [REG_AW-1:0] o_exe_reg_rd,
  output logic              o_exe_reg_reg_wen,
  output logic              o_exe_reg_mem_ren,
  output logic              o_exe_valid,
`ifdef YSYX_22040125_HAZARD_PERF_EN
  output logic [31:0]       o_perf_lu_cnt,
  output logic [31:0]       o_perf_jalr_cnt,
`endif
  output logic              o_pc_stall,
  output logic              o_if_id_stall
);

  import ysyx_22040125_pipe_pkg::*;

  logic [REG_AW-1:0]   r_rs1;
  logic [REG_AW-1:0]   r_rs2;
  logic [REG_AW-1:0]   r_rd;
  idex_ctrl_t          r_ctrl;
  logic [STALL_CW-1:0] r_stall_cnt;

  logic [STALL_CW-1:0] w_need_lu;
  logic [STALL_CW-1:0] w_need_jalr;
  logic [STALL_CW-1:0] w_need;
  logic                w_cnt_idle;
  logic                w_stall_active;
  logic                w_stall_start;
  logic                w_hold;

  assign w_cnt_idle = (r_stall_cnt == '0);

  ysyx_22040125_hazard_detect #(
    .REG_AW   (REG_AW),
    .STALL_CW (STALL_CW)
  ) u_hazard_detect (
    .i_stall_idle  (w_cnt_idle),
    .i_id_valid    (i_id_valid),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_id_is_jalr  (i_id_is_jalr),
    .i_exe_valid   (r_ctrl.valid),
    .i_exe_rd      (r_rd),
    .i_exe_reg_wen (r_ctrl.reg_wen),
    .i_exe_mem_ren (r_ctrl.mem_ren),
    .i_mem_rd      (i_mem_reg_rd),
    .i_mem_reg_wen (i_mem_reg_reg_wen),
    .i_mem_mem_ren (i_mem_reg_mem_ren),
    .o_need_lu     (w_need_lu),
    .o_need_jalr   (w_need_jalr)
  );

  // Overall need is the longest stall any active hazard asks for
  assign w_need         = (w_need_lu > w_need_jalr) ? w_need_lu : w_need_jalr;
  assign w_stall_active = !w_cnt_idle || (w_need != '0);
  // A new stall begins only when the stall branch is actually taken
  assign w_stall_start  = !i_mem_busy && !i_exe_flush && w_cnt_idle && (w_need != '0);

  // Freeze on memory wait, or hold ID while a hazard stall is pending;
  // a redirect releases the front end even mid-stall. Forced low in reset.
  assign w_hold        = i_mem_busy || (!i_exe_flush && w_stall_active);
  assign o_pc_stall    = rst_n & w_hold;
  assign o_if_id_stall = rst_n & w_hold;

  // ID/EX register and stall counter, updated by the per-cycle priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_ctrl      <= IDEX_CTRL_BUBBLE;
      r_stall_cnt <= '0;
    end else if (i_mem_busy) begin
      r_stall_cnt <= r_stall_cnt;
    end else if (i_exe_flush) begin
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_ctrl      <= IDEX_CTRL_BUBBLE;
      r_stall_cnt <= '0;
    end else if (w_stall_active) begin
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_ctrl <= IDEX_CTRL_BUBBLE;
      if (w_cnt_idle) begin
        r_stall_cnt <= w_need - STALL_CW'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt - STALL_CW'(1);
      end
    end else if (i_id_valid) begin
      r_rs1          <= i_id_rs1;
      r_rs2          <= i_id_rs2;
      r_rd           <= i_id_rd;
      r_ctrl.valid   <= 1'b1;
      r_ctrl.reg_wen <= i_id_reg_wen;
      r_ctrl.mem_ren <= i_id_mem_ren;
    end else begin
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_ctrl <= IDEX_CTRL_BUBBLE;
    end
  end

  assign o_exe_reg_rs1     = r_rs1;
  assign o_exe_reg_rs2     = r_rs2;
  assign o_exe_reg_rd      = r_rd;
  assign o_exe_reg_reg_wen = r_ctrl.reg_wen;
  assign o_exe_reg_mem_ren = r_ctrl.mem_ren;
  assign o_exe_valid       = r_ctrl.valid;

`ifdef YSYX_22040125_HAZARD_PERF_EN
  logic [31:0] r_perf_lu_cnt;
  logic [31:0] r_perf_jalr_cnt;

  // Accumulate stall cycles at stall start; load-use wins attribution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lu_cnt   <= '0;
      r_perf_jalr_cnt <= '0;
    end else if (w_stall_start) begin
      if (w_need_lu != '0) begin
        r_perf_lu_cnt <= sat_add32(r_perf_lu_cnt, 32'(w_need));
      end else begin
        r_perf_jalr_cnt <= sat_add32(r_perf_jalr_cnt, 32'(w_need));
      end
    end
  end

  assign o_perf_lu_cnt   = r_perf_lu_cnt;
  assign o_perf_jalr_cnt = r_perf_jalr_cnt;
`else
  logic w_unused_start;
  assign w_unused_start = w_stall_start;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040125_id_exe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040125_id_exe_hazard
// Purpose  : Directed scenarios plus randomized stimulus against a
//            cycle-level reference model of the ID/EX hazard slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040125_id_exe_hazard;

  logic       clk;
  logic       rst_n;
  logic       i_id_valid;
  logic [4:0] i_id_rs1;
  logic [4:0] i_id_rs2;
  logic       i_id_rs1_used;
  logic       i_id_rs2_used;
  logic [4:0] i_id_rd;
  logic       i_id_reg_wen;
  logic       i_id_mem_ren;
  logic       i_id_is_jalr;
  logic [4:0] i_mem_reg_rd;
  logic       i_mem_reg_reg_wen;
  logic       i_mem_reg_mem_ren;
  logic       i_mem_busy;
  logic       i_exe_flush;
  logic [4:0] o_exe_reg_rs1;
  logic [4:0] o_exe_reg_rs2;
  logic [4:0] o_exe_reg_rd;
  logic       o_exe_reg_reg_wen;
  logic       o_exe_reg_mem_ren;
  logic       o_exe_valid;
  logic       o_pc_stall;
  logic       o_if_id_stall;
`ifdef YSYX_22040125_HAZARD_PERF_EN
  logic [31:0] o_perf_lu_cnt;
  logic [31:0] o_perf_jalr_cnt;
`endif

  ysyx_22040125_id_exe_hazard dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_id_valid        (i_id_valid),
    .i_id_rs1          (i_id_rs1),
    .i_id_rs2          (i_id_rs2),
    .i_id_rs1_used     (i_id_rs1_used),
    .i_id_rs2_used     (i_id_rs2_used),
    .i_id_rd           (i_id_rd),
    .i_id_reg_wen      (i_id_reg_wen),
    .i_id_mem_ren      (i_id_mem_ren),
    .i_id_is_jalr      (i_id_is_jalr),
    .i_mem_reg_rd      (i_mem_reg_rd),
    .i_mem_reg_reg_wen (i_mem_reg_reg_wen),
    .i_mem_reg_mem_ren (i_mem_reg_mem_ren),
    .i_mem_busy        (i_mem_busy),
    .i_exe_flush       (i_exe_flush),
    .o_exe_reg_rs1     (o_exe_reg_rs1),
    .o_exe_reg_rs2     (o_exe_reg_rs2),
    .o_exe_reg_rd      (o_exe_reg_rd),
    .o_exe_reg_reg_wen (o_exe_reg_reg_wen),
    .o_exe_reg_mem_ren (o_exe_reg_mem_ren),
    .o_exe_valid       (o_exe_valid),
`ifdef YSYX_22040125_HAZARD_PERF_EN
    .o_perf_lu_cnt     (o_perf_lu_cnt),
    .o_perf_jalr_cnt   (o_perf_jalr_cnt),
`endif
    .o_pc_stall        (o_pc_stall),
    .o_if_id_stall     (o_if_id_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what EXE holds and how many stall cycles remain
  int m_valid, m_rs1, m_rs2, m_rd, m_wen, m_ren, m_cnt;
  longint m_perf_lu, m_perf_jalr;
  int last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wen = 0; m_ren = 0; m_cnt = 0;
    m_perf_lu = 0; m_perf_jalr = 0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wen = 0; m_ren = 0;
  endtask

  task automatic idle_inputs();
    i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_rs1_used = 0; i_id_rs2_used = 0;
    i_id_rd = 0; i_id_reg_wen = 0; i_id_mem_ren = 0; i_id_is_jalr = 0;
    i_mem_reg_rd = 0; i_mem_reg_reg_wen = 0; i_mem_reg_mem_ren = 0;
    i_mem_busy = 0; i_exe_flush = 0;
  endtask

  task automatic set_id(input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit wen, input bit ren, input bit jalr);
    i_id_valid = 1; i_id_rd = 5'(rd); i_id_rs1 = 5'(rs1); i_id_rs2 = 5'(rs2);
    i_id_rs1_used = u1; i_id_rs2_used = u2; i_id_reg_wen = wen; i_id_mem_ren = ren;
    i_id_is_jalr = jalr;
  endtask

  task automatic check_regs();
    check("exe_valid", o_exe_valid, m_valid);
    check("exe_rs1", o_exe_reg_rs1, m_rs1);
    check("exe_rs2", o_exe_reg_rs2, m_rs2);
    check("exe_rd", o_exe_reg_rd, m_rd);
    check("exe_wen", o_exe_reg_reg_wen, m_wen);
    check("exe_ren", o_exe_reg_mem_ren, m_ren);
    check("stall_cnt", dut.r_stall_cnt, m_cnt);
`ifdef YSYX_22040125_HAZARD_PERF_EN
    check("perf_lu", o_perf_lu_cnt, (m_perf_lu > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_perf_lu));
    check("perf_jalr", o_perf_jalr_cnt, (m_perf_jalr > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_perf_jalr));
`endif
  endtask

  // One clock: inputs are already driven just after a falling edge
  task automatic cycle();
    int need_lu, need_jr, need, exp_stall;
    #1;
    need_lu = 0;
    need_jr = 0;
    if (m_cnt == 0 && i_id_valid) begin
      if (m_valid && m_ren && m_rd != 0 &&
          ((i_id_rs1_used && i_id_rs1 == m_rd) || (i_id_rs2_used && i_id_rs2 == m_rd)))
        need_lu = 1;
      if (i_id_is_jalr && m_valid && m_wen && m_rd != 0 && i_id_rs1 == m_rd)
        need_jr = m_ren ? 2 : 1;
      if (i_id_is_jalr && i_mem_reg_reg_wen && i_mem_reg_mem_ren && i_mem_reg_rd != 0 &&
          i_id_rs1 == i_mem_reg_rd && need_jr < 1)
        need_jr = 1;
    end
    need = (need_lu > need_jr) ? need_lu : need_jr;
    if (i_mem_busy)       exp_stall = 1;
    else if (i_exe_flush) exp_stall = 0;
    else                  exp_stall = (m_cnt != 0 || need != 0) ? 1 : 0;
    check("pc_stall", o_pc_stall, exp_stall);
    check("if_id_stall", o_if_id_stall, exp_stall);
    last_stall = o_pc_stall;
    @(posedge clk);
    if (i_mem_busy) begin
      // everything holds
    end else if (i_exe_flush) begin
      model_bubble();
      m_cnt = 0;
    end else if (m_cnt != 0 || need != 0) begin
      model_bubble();
      if (m_cnt == 0) begin
        if (need_lu != 0) m_perf_lu += need;
        else              m_perf_jalr += need;
        m_cnt = need - 1;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else if (i_id_valid) begin
      m_valid = 1; m_rs1 = i_id_rs1; m_rs2 = i_id_rs2; m_rd = i_id_rd;
      m_wen = i_id_reg_wen; m_ren = i_id_mem_ren;
    end else begin
      model_bubble();
    end
    #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    i_mem_busy = 1;
    model_reset();
    #2;
    check("reset_pc_stall", o_pc_stall, 0);
    check_regs();
    i_mem_busy = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: ld x5 then add x6,x5,x7
    set_id(5, 2, 0, 1, 0, 1, 1, 0);
    cycle();
    set_id(6, 5, 7, 1, 1, 1, 0, 0);
    cycle();
    check("lu_stall", last_stall, 1);
    check("lu_bubble", o_exe_valid, 0);
    cycle();
    check("lu_adv_stall", last_stall, 0);
    check("lu_adv_rs1", o_exe_reg_rs1, 5);
    check("lu_adv_valid", o_exe_valid, 1);

    // JALR after a load: two stall cycles, counter 1 then 0
    set_id(1, 3, 0, 1, 0, 1, 1, 0);
    cycle();
    set_id(0, 1, 0, 1, 0, 0, 0, 1);
    cycle();
    check("jl_cnt1", dut.r_stall_cnt, 1);
    cycle();
    check("jl_stall2", last_stall, 1);
    check("jl_cnt0", dut.r_stall_cnt, 0);
    cycle();
    check("jl_adv_stall", last_stall, 0);
    check("jl_adv_valid", o_exe_valid, 1);

    // JALR after ALU op: exactly one stall cycle
    set_id(1, 2, 0, 1, 0, 1, 0, 0);
    cycle();
    set_id(0, 1, 0, 1, 0, 0, 0, 1);
    cycle();
    check("ja_stall", last_stall, 1);
    check("ja_cnt", dut.r_stall_cnt, 0);
    cycle();
    check("ja_adv_stall", last_stall, 0);

    // Flush on second cycle of a 2-cycle stall
    set_id(1, 3, 0, 1, 0, 1, 1, 0);
    cycle();
    set_id(0, 1, 0, 1, 0, 0, 0, 1);
    cycle();
    i_exe_flush = 1;
    cycle();
    check("fl_stall", last_stall, 0);
    check("fl_cnt", dut.r_stall_cnt, 0);
    check("fl_valid", o_exe_valid, 0);
    i_exe_flush = 0;

    // mem_busy freeze for three cycles
    set_id(3, 2, 0, 1, 0, 1, 0, 0);
    cycle();
    set_id(4, 6, 0, 1, 0, 1, 0, 0);
    i_mem_busy = 1;
    repeat (3) begin
      cycle();
      check("mb_hold_rd", o_exe_reg_rd, 3);
      check("mb_stall", last_stall, 1);
    end
    i_mem_busy = 0;
    cycle();
    check("mb_rel_rd", o_exe_reg_rd, 4);
    check("mb_rel_valid", o_exe_valid, 1);

    // x0 load never stalls a reader of x0
    set_id(0, 2, 0, 1, 0, 1, 1, 0);
    cycle();
    set_id(6, 0, 0, 1, 1, 1, 0, 0);
    cycle();
    check("x0_stall", last_stall, 0);
    check("x0_valid", o_exe_valid, 1);

    // Async reset mid-stall
    set_id(1, 3, 0, 1, 0, 1, 1, 0);
    cycle();
    set_id(0, 1, 0, 1, 0, 0, 0, 1);
    cycle();
    check("ar_pre_cnt", dut.r_stall_cnt, 1);
    #2;
    i_mem_busy = 1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_pc_stall", o_pc_stall, 0);
    check("ar_if_id_stall", o_if_id_stall, 0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      i_id_valid        = ($urandom_range(0, 9) != 0);
      i_id_rs1          = 5'($urandom_range(0, 3));
      i_id_rs2          = 5'($urandom_range(0, 3));
      i_id_rs1_used     = 1'($urandom);
      i_id_rs2_used     = 1'($urandom);
      i_id_rd           = 5'($urandom_range(0, 3));
      i_id_reg_wen      = ($urandom_range(0, 3) != 0);
      i_id_mem_ren      = ($urandom_range(0, 2) == 0);
      i_id_is_jalr      = ($urandom_range(0, 3) == 0);
      i_mem_reg_rd      = 5'($urandom_range(0, 3));
      i_mem_reg_reg_wen = 1'($urandom);
      i_mem_reg_mem_ren = 1'($urandom);
      i_mem_busy        = ($urandom_range(0, 9) == 0);
      i_exe_flush       = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
